// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Round-robin arbiter that shares one uart_drive TX channel between P_NUM
// byte-stream requesters. Ownership is granted per frame (closed by a last
// flag), capped at P_MAX_BURST bytes, and reclaimed after P_IDLE_TIMEOUT
// cycles without data from the owner. One byte hold register sits between
// the winning requester and uart_drive.
module uart_tx_arbiter #(
  parameter int P_NUM          = 3,
  parameter int P_MAX_BURST    = 64,
  parameter int P_IDLE_TIMEOUT = 1024
) (
  input  logic               w_user_clk,
  input  logic               w_user_rst,
  input  logic [P_NUM-1:0]   i_req_valid,
  input  logic [8*P_NUM-1:0] i_req_data,
  input  logic [P_NUM-1:0]   i_req_last,
  output logic [P_NUM-1:0]   o_req_ready,
  output logic [7:0]         o_tx_data,
  output logic               o_tx_valid,
  input  logic               i_tx_ready,
  output logic [P_NUM-1:0]   o_grant,
  output logic               o_busy
);

  localparam int PW = (P_NUM > 1) ? $clog2(P_NUM) : 1;
  localparam int CW = PW + 1;
  localparam int BW = (P_MAX_BURST > 0) ? $clog2(P_MAX_BURST + 1) : 1;
  localparam int TW = (P_IDLE_TIMEOUT > 0) ? $clog2(P_IDLE_TIMEOUT + 1) : 1;

  localparam logic [BW-1:0] BURST_CAP = BW'(P_MAX_BURST);
  localparam logic [TW-1:0] TMO_MAX   = TW'(P_IDLE_TIMEOUT);
  localparam logic [PW-1:0] PTR_INIT  = PW'(P_NUM - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOCK,
    ST_DRAIN
  } state_t;

  state_t           state_reg, state_next;
  logic [PW-1:0]    ptr_reg, ptr_next;
  logic [PW-1:0]    gidx_reg, gidx_next;
  logic [P_NUM-1:0] grant_reg, grant_next;
  logic [BW-1:0]    burst_reg, burst_next;
  logic [TW-1:0]    tmo_reg, tmo_next;
  logic             hold_full_reg, hold_full_next;
  logic [7:0]       tx_data_reg, tx_data_next;

  logic [7:0]       req_byte [P_NUM];
  logic             sel_valid, sel_last;
  logic [7:0]       sel_byte;
  logic             in_lock, hold_empty, accept, tx_done, idle_tick;
  logic             cap_hit, tmo_hit;
  logic             arb_found;
  logic [PW-1:0]    arb_idx;
  logic [CW-1:0]    cand;

  // Split the flat data bus into one byte lane per requester
  generate
    for (genvar gi = 0; gi < P_NUM; gi++) begin : g_lane
      assign req_byte[gi] = i_req_data[8*gi +: 8];
    end
  endgenerate

  assign sel_valid  = i_req_valid[gidx_reg];
  assign sel_last   = i_req_last[gidx_reg];
  assign sel_byte   = req_byte[gidx_reg];
  assign in_lock    = (state_reg == ST_LOCK);
  assign hold_empty = !hold_full_reg;
  assign accept     = in_lock && hold_empty && sel_valid;
  assign tx_done    = hold_full_reg && i_tx_ready;
  assign idle_tick  = in_lock && hold_empty && !sel_valid;
  // Release on the accept that brings the burst count up to the cap
  assign cap_hit    = (P_MAX_BURST > 0) && ((burst_reg + BW'(1)) == BURST_CAP);
  // Release on the idle cycle that brings the timeout count up to its limit
  assign tmo_hit    = (P_IDLE_TIMEOUT > 0) && ((tmo_reg + TW'(1)) == TMO_MAX);

  assign o_req_ready = (in_lock && hold_empty) ? grant_reg : '0;
  assign o_grant     = grant_reg;
  assign o_busy      = (state_reg != ST_IDLE);
  assign o_tx_valid  = hold_full_reg;
  assign o_tx_data   = tx_data_reg;

  // Round-robin search: first valid requester after the last owner
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = '0;
    for (int i = 1; i <= P_NUM; i++) begin
      cand = CW'(ptr_reg) + CW'(i);
      if (cand >= CW'(P_NUM)) begin
        cand = cand - CW'(P_NUM);
      end
      if (!arb_found && i_req_valid[cand[PW-1:0]]) begin
        arb_found = 1'b1;
        arb_idx   = cand[PW-1:0];
      end
    end
  end

  // Next-state logic for the grant FSM, counters and hold register
  always_comb begin
    state_next     = state_reg;
    ptr_next       = ptr_reg;
    gidx_next      = gidx_reg;
    grant_next     = grant_reg;
    burst_next     = burst_reg;
    tmo_next       = tmo_reg;
    hold_full_next = hold_full_reg;
    tx_data_next   = tx_data_reg;

    // accept needs an empty hold and tx_done a full one, so never both
    if (accept) begin
      hold_full_next = 1'b1;
      tx_data_next   = sel_byte;
    end else if (tx_done) begin
      hold_full_next = 1'b0;
    end

    case (state_reg)
      ST_IDLE: begin
        if (arb_found) begin
          gidx_next           = arb_idx;
          grant_next          = '0;
          grant_next[arb_idx] = 1'b1;
          state_next          = ST_LOCK;
        end
      end
      ST_LOCK: begin
        if (accept) begin
          burst_next = burst_reg + BW'(1);
          tmo_next   = '0;
          if (sel_last || cap_hit) begin
            state_next = ST_DRAIN;
          end
        end else if (idle_tick) begin
          if (tmo_reg != TMO_MAX) begin
            tmo_next = tmo_reg + TW'(1);
          end
          if (tmo_hit) begin
            state_next = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        // Hand back only once the owner's last byte has left the hold register
        if (!hold_full_reg) begin
          state_next = ST_IDLE;
          ptr_next   = gidx_reg;
          grant_next = '0;
          burst_next = '0;
          tmo_next   = '0;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any byte in the hold register
  always_ff @(posedge w_user_clk or posedge w_user_rst) begin
    if (w_user_rst) begin
      state_reg     <= ST_IDLE;
      ptr_reg       <= PTR_INIT;
      gidx_reg      <= '0;
      grant_reg     <= '0;
      burst_reg     <= '0;
      tmo_reg       <= '0;
      hold_full_reg <= 1'b0;
      tx_data_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      ptr_reg       <= ptr_next;
      gidx_reg      <= gidx_next;
      grant_reg     <= grant_next;
      burst_reg     <= burst_next;
      tmo_reg       <= tmo_next;
      hold_full_reg <= hold_full_next;
      tx_data_reg   <= tx_data_next;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: three requesters, burst cap 4, idle timeout 16.
// Requester queues feed the DUT; expected TX order comes from a frame-level
// round-robin model working directly on the queue contents.
module tb_uart_tx_arbiter;

  localparam int NR    = 3;
  localparam int BURST = 4;
  localparam int TMO   = 16;

  logic            w_user_clk = 1'b0;
  logic            w_user_rst;
  logic [NR-1:0]   i_req_valid;
  logic [8*NR-1:0] i_req_data;
  logic [NR-1:0]   i_req_last;
  logic [NR-1:0]   o_req_ready;
  logic [7:0]      o_tx_data;
  logic            o_tx_valid;
  logic            i_tx_ready;
  logic [NR-1:0]   o_grant;
  logic            o_busy;

  int compared   = 0;
  int mismatched = 0;

  // Per-requester pending bytes: {last, data}
  logic [8:0]    q [NR][$];
  // Expected TX stream: {requester, data}
  logic [9:0]    exp_q [$];
  logic [NR-1:0] req_en;

  uart_tx_arbiter #(
    .P_NUM          (NR),
    .P_MAX_BURST    (BURST),
    .P_IDLE_TIMEOUT (TMO)
  ) dut (
    .w_user_clk  (w_user_clk),
    .w_user_rst  (w_user_rst),
    .i_req_valid (i_req_valid),
    .i_req_data  (i_req_data),
    .i_req_last  (i_req_last),
    .o_req_ready (o_req_ready),
    .o_tx_data   (o_tx_data),
    .o_tx_valid  (o_tx_valid),
    .i_tx_ready  (i_tx_ready),
    .o_grant     (o_grant),
    .o_busy      (o_busy)
  );

  always #5 w_user_clk = ~w_user_clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got running, required finished");
    $fatal(1, "watchdog");
  end

  function automatic logic [NR-1:0] oh(input logic [1:0] k);
    oh    = '0;
    oh[k] = 1'b1;
  endfunction

  task automatic push(input int k, input logic [7:0] b, input logic l);
    q[k].push_back({l, b});
  endtask

  task automatic drive_inputs();
    logic [8:0] h;
    for (int k = 0; k < NR; k++) begin
      if (q[k].size() > 0 && req_en[k]) begin
        h                   = q[k][0];
        i_req_valid[k]      = 1'b1;
        i_req_data[8*k +: 8] = h[7:0];
        i_req_last[k]       = h[8];
      end else begin
        i_req_valid[k]      = 1'b0;
        i_req_data[8*k +: 8] = 8'h00;
        i_req_last[k]       = 1'b0;
      end
    end
  endtask

  // One clock: sample at negedge, pop accepted bytes after the rising edge
  task automatic step(output logic hs, output logic [7:0] d, output logic [NR-1:0] g);
    logic [NR-1:0] acc;
    @(negedge w_user_clk);
    hs  = o_tx_valid & i_tx_ready;
    d   = o_tx_data;
    g   = o_grant;
    acc = o_req_ready & i_req_valid;
    if (hs) $display("[%0t] tx grant=%b data=%02h", $time, g, d);
    @(posedge w_user_clk);
    #1;
    for (int k = 0; k < NR; k++) begin
      if (acc[k] && q[k].size() > 0) q[k].delete(0);
    end
    drive_inputs();
  endtask

  task automatic reset_dut();
    w_user_rst = 1'b1;
    for (int k = 0; k < NR; k++) q[k].delete();
    req_en     = '1;
    i_tx_ready = 1'b1;
    drive_inputs();
    repeat (2) @(posedge w_user_clk);
    #1 w_user_rst = 1'b0;
  endtask

  // Frame-level model: every requester with pending bytes is requesting;
  // the winner is the first such index after the previous owner, and it
  // sends until a last byte or BURST bytes, whichever comes first.
  task automatic build_expected(input int start_ptr);
    logic [8:0] mq [NR][$];
    logic [8:0] e;
    int p, w, n, c;
    exp_q.delete();
    for (int k = 0; k < NR; k++) mq[k] = q[k];
    p = start_ptr;
    while (1) begin
      w = -1;
      for (int i = 1; i <= NR; i++) begin
        c = (p + i) % NR;
        if (w < 0 && mq[c].size() > 0) w = c;
      end
      if (w < 0) break;
      n = 0;
      while (mq[w].size() > 0) begin
        e = mq[w].pop_front();
        exp_q.push_back({2'(w), e[7:0]});
        n++;
        if (e[8] || n == BURST) break;
      end
      p = w;
    end
  endtask

  task automatic test_reset();
    w_user_rst = 1'b1;
    req_en     = '1;
    i_tx_ready = 1'b1;
    for (int k = 0; k < NR; k++) q[k].delete();
    push(0, 8'hAA, 1'b1);
    push(1, 8'hBB, 1'b1);
    drive_inputs();
    repeat (3) @(posedge w_user_clk);
    #1;
    compared++;
    if (o_tx_valid !== 1'b0) begin mismatched++; $display("FAIL reset_tx_valid got %b want 0", o_tx_valid); end
    compared++;
    if (o_tx_data !== 8'h00) begin mismatched++; $display("FAIL reset_tx_data got %h want 00", o_tx_data); end
    compared++;
    if (o_grant !== 3'b000) begin mismatched++; $display("FAIL reset_grant got %b want 000", o_grant); end
    compared++;
    if (o_busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy got %b want 0", o_busy); end
    compared++;
    if (o_req_ready !== 3'b000) begin mismatched++; $display("FAIL reset_req_ready got %b want 000", o_req_ready); end
    w_user_rst = 1'b0;
  endtask

  task automatic test_single_frame();
    logic [7:0] want [3];
    logic hs; logic [7:0] d; logic [NR-1:0] g;
    int cnt, n;
    want[0] = 8'h41; want[1] = 8'h42; want[2] = 8'h43;
    reset_dut();
    push(0, 8'h41, 1'b0);
    push(0, 8'h42, 1'b0);
    push(0, 8'h43, 1'b1);
    drive_inputs();
    compared++;
    if (o_grant !== 3'b000) begin mismatched++; $display("FAIL single_grant_before got %b want 000", o_grant); end
    step(hs, d, g);
    compared++;
    if (o_grant !== 3'b001) begin mismatched++; $display("FAIL single_grant_cycle1 got %b want 001", o_grant); end
    cnt = 0;
    n   = 0;
    while (cnt < 3 && n < 40) begin
      step(hs, d, g);
      n++;
      if (hs) begin
        compared++;
        if (d !== want[cnt]) begin mismatched++; $display("FAIL single_byte%0d got %h want %h", cnt, d, want[cnt]); end
        cnt++;
      end
    end
    compared++;
    if (cnt != 3) begin mismatched++; $display("FAIL single_count got %0d want 3", cnt); end
    compared++;
    if (o_grant !== 3'b001 || o_busy !== 1'b1) begin
      mismatched++; $display("FAIL single_drain got grant %b busy %b want 001 1", o_grant, o_busy);
    end
    step(hs, d, g);
    compared++;
    if (o_grant !== 3'b000 || o_busy !== 1'b0) begin
      mismatched++; $display("FAIL single_idle got grant %b busy %b want 000 0", o_grant, o_busy);
    end
  endtask

  task automatic test_round_robin();
    logic hs; logic [7:0] d; logic [NR-1:0] g; logic [9:0] ex;
    int n;
    reset_dut();
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < NR; k++) push(k, 8'($urandom), 1'b1);
    end
    drive_inputs();
    build_expected(NR - 1);
    n = 0;
    while (exp_q.size() > 0 && n < 200) begin
      step(hs, d, g);
      n++;
      if (hs) begin
        ex = exp_q.pop_front();
        compared++;
        if (d !== ex[7:0] || g !== oh(ex[9:8])) begin
          mismatched++; $display("FAIL rr_byte got data %h grant %b want data %h grant %b", d, g, ex[7:0], oh(ex[9:8]));
        end
      end
    end
    compared++;
    if (exp_q.size() != 0) begin mismatched++; $display("FAIL rr_complete got %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_burst_cap();
    logic hs; logic [7:0] d; logic [NR-1:0] g; logic [9:0] ex;
    int n;
    reset_dut();
    for (int i = 1; i <= 10; i++) push(1, 8'(8'h10 + i), (i == 10));
    push(2, 8'hE0, 1'b1);
    drive_inputs();
    build_expected(NR - 1);
    n = 0;
    while (exp_q.size() > 0 && n < 200) begin
      step(hs, d, g);
      n++;
      if (hs) begin
        ex = exp_q.pop_front();
        compared++;
        if (d !== ex[7:0] || g !== oh(ex[9:8])) begin
          mismatched++; $display("FAIL burst_byte got data %h grant %b want data %h grant %b", d, g, ex[7:0], oh(ex[9:8]));
        end
      end
    end
    compared++;
    if (exp_q.size() != 0) begin mismatched++; $display("FAIL burst_complete got %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_timeout();
    logic hs; logic [7:0] d; logic [NR-1:0] g;
    int n;
    reset_dut();
    push(0, 8'h77, 1'b0);
    push(2, 8'h99, 1'b1);
    drive_inputs();
    hs = 1'b0; n = 0;
    while (!hs && n < 20) begin step(hs, d, g); n++; end
    compared++;
    if (!hs || d !== 8'h77) begin mismatched++; $display("FAIL tmo_first_byte got hs %b data %h want 1 77", hs, d); end
    repeat (TMO - 1) step(hs, d, g);
    compared++;
    if (o_req_ready !== 3'b001 || o_grant !== 3'b001) begin
      mismatched++; $display("FAIL tmo_held got ready %b grant %b want 001 001", o_req_ready, o_grant);
    end
    step(hs, d, g);
    compared++;
    if (o_req_ready !== 3'b000 || o_busy !== 1'b1) begin
      mismatched++; $display("FAIL tmo_release got ready %b busy %b want 000 1", o_req_ready, o_busy);
    end
    step(hs, d, g);
    compared++;
    if (o_grant !== 3'b000 || o_busy !== 1'b0) begin
      mismatched++; $display("FAIL tmo_idle got grant %b busy %b want 000 0", o_grant, o_busy);
    end
    step(hs, d, g);
    compared++;
    if (o_grant !== 3'b100) begin mismatched++; $display("FAIL tmo_next_grant got %b want 100", o_grant); end
    hs = 1'b0; n = 0;
    while (!hs && n < 10) begin step(hs, d, g); n++; end
    compared++;
    if (!hs || d !== 8'h99) begin mismatched++; $display("FAIL tmo_req2_byte got hs %b data %h want 1 99", hs, d); end
  endtask

  task automatic test_tx_stall();
    logic hs; logic [7:0] d; logic [NR-1:0] g;
    int n, n5a, n33;
    reset_dut();
    i_tx_ready = 1'b0;
    push(0, 8'h5A, 1'b0);
    push(0, 8'h33, 1'b1);
    drive_inputs();
    n = 0;
    while (!o_tx_valid && n < 10) begin step(hs, d, g); n++; end
    compared++;
    if (o_tx_valid !== 1'b1) begin mismatched++; $display("FAIL stall_load got valid %b want 1", o_tx_valid); end
    for (int c = 0; c < 500; c++) begin
      step(hs, d, g);
      compared++;
      if (o_tx_valid !== 1'b1 || o_tx_data !== 8'h5A || o_req_ready !== 3'b000) begin
        mismatched++;
        $display("FAIL stall_hold cycle %0d got valid %b data %h ready %b want 1 5a 000", c, o_tx_valid, o_tx_data, o_req_ready);
      end
    end
    i_tx_ready = 1'b1;
    step(hs, d, g);
    compared++;
    if (!hs || d !== 8'h5A) begin mismatched++; $display("FAIL stall_handshake got hs %b data %h want 1 5a", hs, d); end
    compared++;
    if (o_tx_valid !== 1'b0) begin mismatched++; $display("FAIL stall_empty got valid %b want 0", o_tx_valid); end
    n5a = 0; n33 = 0;
    repeat (10) begin
      step(hs, d, g);
      if (hs && d === 8'h5A) n5a++;
      if (hs && d === 8'h33) n33++;
    end
    compared++;
    if (n5a != 0 || n33 != 1) begin mismatched++; $display("FAIL stall_once got extra5a %0d count33 %0d want 0 1", n5a, n33); end
  endtask

  task automatic test_reset_mid_frame();
    logic hs; logic [7:0] d; logic [NR-1:0] g; logic [9:0] ex;
    int n;
    reset_dut();
    push(0, 8'h01, 1'b1);
    drive_inputs();
    hs = 1'b0; n = 0;
    while (!hs && n < 20) begin step(hs, d, g); n++; end
    repeat (2) step(hs, d, g);
    i_tx_ready = 1'b0;
    push(1, 8'hC1, 1'b0);
    push(1, 8'hC2, 1'b1);
    drive_inputs();
    n = 0;
    while (!o_tx_valid && n < 10) begin step(hs, d, g); n++; end
    compared++;
    if (o_grant !== 3'b010 || o_tx_valid !== 1'b1) begin
      mismatched++; $display("FAIL rstmid_setup got grant %b valid %b want 010 1", o_grant, o_tx_valid);
    end
    #2 w_user_rst = 1'b1;
    #1;
    compared++;
    if (o_tx_valid !== 1'b0 || o_tx_data !== 8'h00) begin
      mismatched++; $display("FAIL rstmid_tx got valid %b data %h want 0 00", o_tx_valid, o_tx_data);
    end
    compared++;
    if (o_grant !== 3'b000 || o_busy !== 1'b0 || o_req_ready !== 3'b000) begin
      mismatched++; $display("FAIL rstmid_ctrl got grant %b busy %b ready %b want 000 0 000", o_grant, o_busy, o_req_ready);
    end
    for (int k = 0; k < NR; k++) q[k].delete();
    push(0, 8'hA0, 1'b1);
    push(1, 8'hB0, 1'b1);
    i_tx_ready = 1'b1;
    drive_inputs();
    @(posedge w_user_clk);
    #1 w_user_rst = 1'b0;
    build_expected(NR - 1);
    step(hs, d, g);
    compared++;
    if (o_grant !== 3'b001) begin mismatched++; $display("FAIL rstmid_first_grant got %b want 001", o_grant); end
    n = 0;
    while (exp_q.size() > 0 && n < 40) begin
      step(hs, d, g);
      n++;
      if (hs) begin
        ex = exp_q.pop_front();
        compared++;
        if (d !== ex[7:0] || g !== oh(ex[9:8])) begin
          mismatched++; $display("FAIL rstmid_byte got data %h grant %b want data %h grant %b", d, g, ex[7:0], oh(ex[9:8]));
        end
      end
    end
    compared++;
    if (exp_q.size() != 0) begin mismatched++; $display("FAIL rstmid_complete got %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_random();
    logic hs; logic [7:0] d; logic [NR-1:0] g; logic [9:0] ex;
    int n, nf, len;
    for (int it = 0; it < 3; it++) begin
      reset_dut();
      for (int k = 0; k < NR; k++) begin
        nf = $urandom_range(0, 4);
        for (int f = 0; f < nf; f++) begin
          len = $urandom_range(1, 7);
          for (int b = 0; b < len; b++) push(k, 8'($urandom), (b == len - 1));
        end
      end
      drive_inputs();
      build_expected(NR - 1);
      n = 0;
      while (exp_q.size() > 0 && n < 3000) begin
        i_tx_ready = ($urandom_range(0, 3) != 0);
        step(hs, d, g);
        n++;
        if (hs) begin
          ex = exp_q.pop_front();
          compared++;
          if (d !== ex[7:0] || g !== oh(ex[9:8])) begin
            mismatched++; $display("FAIL rand_byte got data %h grant %b want data %h grant %b", d, g, ex[7:0], oh(ex[9:8]));
          end
        end
      end
      compared++;
      if (exp_q.size() != 0) begin mismatched++; $display("FAIL rand_complete got %0d left want 0", exp_q.size()); end
      i_tx_ready = 1'b1;
    end
  endtask

  initial begin
    w_user_rst  = 1'b1;
    i_tx_ready  = 1'b1;
    req_en      = '1;
    i_req_valid = '0;
    i_req_data  = '0;
    i_req_last  = '0;
    test_reset();
    test_single_frame();
    test_round_robin();
    test_burst_cap();
    test_timeout();
    test_tx_stall();
    test_reset_mid_frame();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
